// File: rtl/mitll_ndro_sched_pkg.sv
// Shared types and default parameters for the NDRO cell scheduler.
// Op encoding matches the rq_op bus; state values appear on dbg_state.
package mitll_ndro_sched_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_SET   = 2'b01,
      OP_RESET = 2'b10,
      OP_READ  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RWAIT = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   localparam int DEF_NCELL    = 4;
   localparam int DEF_IDXW     = 2;
   localparam int DEF_CT_RS    = 2;
   localparam int DEF_CT_CR    = 2;
   localparam int DEF_READ_LAT = 4;

endpackage

// File: rtl/mitll_ndro_sched_if.sv
// Request/response bundle between two requesters and the NDRO scheduler.
// Handshake: a request on lane r transfers on a rising clk edge where
// rq_valid[r] & rq_ready[r]; rq_op/rq_idx must be stable while rq_valid[r]
// is high; rsp_valid is a one-cycle strobe with no backpressure.
interface mitll_ndro_sched_if #(
   parameter int IDXW = 2
);
   logic [1:0]           rq_valid;
   logic [1:0]           rq_ready;
   logic [1:0][1:0]      rq_op;
   logic [1:0][IDXW-1:0] rq_idx;
   logic                 rsp_valid;
   logic                 rsp_id;
   logic                 rsp_data;

   modport master (
      output rq_valid, rq_op, rq_idx,
      input  rq_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  rq_valid, rq_op, rq_idx,
      output rq_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mitll_ndro_cell_track.sv
// Per-cell bookkeeping: shadow state, timing guards, toggle-encoded pulse
// lines and detection of output toggles that no read explains.
module mitll_ndro_cell_track #(
   parameter int CT_RS = 2,
   parameter int CT_CR = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic do_set,
   input  logic do_reset,
   input  logic do_read,
   input  logic rd_inflight,
   input  logic out_lvl,
   output logic st,
   output logic set_block,
   output logic reset_block,
   output logic set_lvl,
   output logic reset_lvl,
   output logic clk_lvl,
   output logic stray
);
   localparam int RSW = (CT_RS > 0) ? $clog2(CT_RS + 1) : 1;
   localparam int CRW = (CT_CR > 0) ? $clog2(CT_CR + 1) : 1;

   logic [RSW-1:0] rs_cnt;
   logic [CRW-1:0] cr_cnt;
   logic           out_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= 1'b0;
         set_lvl   <= 1'b0;
         reset_lvl <= 1'b0;
         clk_lvl   <= 1'b0;
         rs_cnt    <= '0;
         cr_cnt    <= '0;
         out_q     <= 1'b0;
      end else begin
         if (do_set) begin
            st      <= 1'b1;
            set_lvl <= ~set_lvl;
         end
         if (do_reset) begin
            st        <= 1'b0;
            reset_lvl <= ~reset_lvl;
         end
         if (do_read) clk_lvl <= ~clk_lvl;

         // A RESET re-arms the guard even when the cell already holds 0.
         if (do_reset)          rs_cnt <= RSW'(CT_RS);
         else if (rs_cnt != '0) rs_cnt <= rs_cnt - RSW'(1);

         if (do_read && st)     cr_cnt <= CRW'(CT_CR);
         else if (cr_cnt != '0) cr_cnt <= cr_cnt - CRW'(1);

         out_q <= out_lvl;
      end
   end

   assign set_block   = (rs_cnt != '0);
   assign reset_block = (cr_cnt != '0);
   assign stray       = (out_lvl != out_q) && !rd_inflight;

endmodule

// File: rtl/mitll_ndro_sched.sv
// Two-requester scheduler for a bank of NDRO cells: round-robin arbitration,
// read sequencing FSM, response generation and sticky error reporting.
module mitll_ndro_sched
   import mitll_ndro_sched_pkg::*;
#(
   parameter int NCELL    = DEF_NCELL,
   parameter int IDXW     = DEF_IDXW,
   parameter int CT_RS    = DEF_CT_RS,
   parameter int CT_CR    = DEF_CT_CR,
   parameter int READ_LAT = DEF_READ_LAT
) (
   input  logic              clk,
   input  logic              reset,
   mitll_ndro_sched_if.slave rq,
   output logic [NCELL-1:0]  ndro_set,
   output logic [NCELL-1:0]  ndro_reset,
   output logic [NCELL-1:0]  ndro_clk,
   input  logic [NCELL-1:0]  ndro_out,
   output logic              err,
   output logic [1:0]        dbg_state
);
   localparam int LW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

   state_t            state;
   logic [LW-1:0]     lat_cnt;
   logic [IDXW-1:0]   rd_idx;
   logic              rd_id;
   logic              rd_latch;
   logic              rr_ptr;

   logic [NCELL-1:0]  st_vec, set_blk, rst_blk, stray, rd_inflight;
   logic [NCELL-1:0]  do_set, do_reset, do_read;
   logic [1:0]        elig, grant;
   logic              win, go, rd_bit;
   op_t               acc_op;
   logic [IDXW-1:0]   acc_idx;

   always_comb begin
      elig = 2'b00;
      for (int r = 0; r < 2; r++) begin
         elig[r] = rq.rq_valid[r] && (state == S_IDLE)
                   && !((op_t'(rq.rq_op[r]) == OP_SET)   && set_blk[rq.rq_idx[r]])
                   && !((op_t'(rq.rq_op[r]) == OP_RESET) && rst_blk[rq.rq_idx[r]]);
      end
      // rr_ptr names the requester preferred when both are eligible.
      win     = (elig == 2'b11) ? rr_ptr : elig[1];
      go      = |elig;
      grant   = go ? (2'b01 << win) : 2'b00;
      acc_op  = op_t'(rq.rq_op[win]);
      acc_idx = rq.rq_idx[win];
   end

   assign rq.rq_ready = reset ? grant : 2'b00;
   assign rd_bit      = ndro_out[rd_idx] ^ rd_latch;
   assign dbg_state   = state;

   for (genvar i = 0; i < NCELL; i++) begin : g_cell
      assign do_set[i]      = go && (acc_op == OP_SET)   && (acc_idx == IDXW'(i));
      assign do_reset[i]    = go && (acc_op == OP_RESET) && (acc_idx == IDXW'(i));
      assign do_read[i]     = go && (acc_op == OP_READ)  && (acc_idx == IDXW'(i));
      assign rd_inflight[i] = (state == S_RWAIT) && (rd_idx == IDXW'(i));

      mitll_ndro_cell_track #(
         .CT_RS (CT_RS),
         .CT_CR (CT_CR)
      ) u_cell (
         .clk         (clk),
         .reset       (reset),
         .do_set      (do_set[i]),
         .do_reset    (do_reset[i]),
         .do_read     (do_read[i]),
         .rd_inflight (rd_inflight[i]),
         .out_lvl     (ndro_out[i]),
         .st          (st_vec[i]),
         .set_block   (set_blk[i]),
         .reset_block (rst_blk[i]),
         .set_lvl     (ndro_set[i]),
         .reset_lvl   (ndro_reset[i]),
         .clk_lvl     (ndro_clk[i]),
         .stray       (stray[i])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         lat_cnt      <= '0;
         rd_idx       <= '0;
         rd_id        <= 1'b0;
         rd_latch     <= 1'b0;
         rr_ptr       <= 1'b0;
         rq.rsp_valid <= 1'b0;
         rq.rsp_id    <= 1'b0;
         rq.rsp_data  <= 1'b0;
         err          <= 1'b0;
      end else begin
         rq.rsp_valid <= 1'b0;
         rq.rsp_data  <= 1'b0;
         if (|stray) err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (go) begin
                  rr_ptr <= ~win;
                  if (acc_op == OP_READ) begin
                     // Reference level for the output-toggle comparison at sample time.
                     state    <= S_RWAIT;
                     lat_cnt  <= LW'(READ_LAT);
                     rd_idx   <= acc_idx;
                     rd_id    <= win;
                     rd_latch <= ndro_out[acc_idx];
                  end else if (acc_op != OP_NOP) begin
                     rq.rsp_valid <= 1'b1;
                     rq.rsp_id    <= win;
                  end
               end
            end
            S_RWAIT: begin
               if (lat_cnt == '0) begin
                  state        <= S_RESP;
                  rq.rsp_valid <= 1'b1;
                  rq.rsp_id    <= rd_id;
                  rq.rsp_data  <= rd_bit;
                  if (rd_bit != st_vec[rd_idx]) err <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - LW'(1);
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mitll_ndro_sched.sv
// Bench for mitll_ndro_sched: directed scenarios plus a randomized run
// against a cycle-numbered reference model and a behavioural NDRO array.
module tb_mitll_ndro_sched;
   import mitll_ndro_sched_pkg::*;

   localparam int NCELL    = 4;
   localparam int IDXW     = 2;
   localparam int CT_RS    = 2;
   localparam int CT_CR    = 2;
   localparam int READ_LAT = 4;
   localparam int NRAND    = 400;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mitll_ndro_sched_if #(.IDXW(IDXW)) bus();
   logic [NCELL-1:0] ndro_set, ndro_reset, ndro_clk, ndro_out;
   logic             err;
   logic [1:0]       dbg_state;

   mitll_ndro_sched #(
      .NCELL(NCELL), .IDXW(IDXW), .CT_RS(CT_RS), .CT_CR(CT_CR), .READ_LAT(READ_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rq         (bus),
      .ndro_set   (ndro_set),
      .ndro_reset (ndro_reset),
      .ndro_clk   (ndro_clk),
      .ndro_out   (ndro_out),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- NDRO array model ----------------
   logic [NCELL-1:0] cell_st, mout, inj, p_set, p_rst, p_clk;
   assign ndro_out = mout ^ inj;

   always @(posedge clk) begin
      #3;
      if (!reset) begin
         cell_st = '0; mout = '0; p_set = '0; p_rst = '0; p_clk = '0;
      end else begin
         for (int i = 0; i < NCELL; i++) begin
            if (ndro_set[i] != p_set[i])   cell_st[i] = 1'b1;
            if (ndro_reset[i] != p_rst[i]) cell_st[i] = 1'b0;
            if ((ndro_clk[i] != p_clk[i]) && cell_st[i]) mout[i] = ~mout[i];
         end
         p_set = ndro_set; p_rst = ndro_reset; p_clk = ndro_clk;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic to_mid();
      #4;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] o0, input logic [IDXW-1:0] i0,
                        input logic [1:0] o1, input logic [IDXW-1:0] i1);
      bus.rq_valid  = v;
      bus.rq_op[0]  = o0;
      bus.rq_idx[0] = i0;
      bus.rq_op[1]  = o1;
      bus.rq_idx[1] = i1;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b0;
      inj   = '0;
      drive(2'b00, OP_NOP, 0, OP_NOP, 0);
      tick(); tick();
      reset = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive(2'b11, OP_SET, 0, OP_SET, 1);
      repeat (3) tick();
      to_mid();
      checks++; if (bus.rq_ready !== 2'b00) begin failures++; $display("FAIL reset.ready got=%b exp=00", bus.rq_ready); end
      checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 1'b0 || bus.rsp_id !== 1'b0) begin failures++; $display("FAIL reset.rsp got=%b%b%b exp=000", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
      checks++; if ({ndro_set, ndro_reset, ndro_clk} !== '0) begin failures++; $display("FAIL reset.ndro got=%h exp=0", {ndro_set, ndro_reset, ndro_clk}); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset.err got=%b exp=0", err); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset.state got=%0d exp=0", dbg_state); end
      tick();
      reset = 1'b1;
      drive(2'b00, OP_NOP, 0, OP_NOP, 0);
   endtask

   task automatic test_set_read();
      logic [NCELL-1:0] s0, c0;
      tick(); drive(2'b01, OP_SET, 2, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL set_read.set_ready got=%b exp=01", bus.rq_ready); end
      s0 = ndro_set;
      tick(); drive(2'b01, OP_READ, 2, OP_NOP, 0); to_mid();
      checks++; if (ndro_set !== (s0 ^ 4'b0100)) begin failures++; $display("FAIL set_read.set_pulse got=%b exp=%b", ndro_set, s0 ^ 4'b0100); end
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 3'b100) begin failures++; $display("FAIL set_read.wr_rsp got=%b exp=100", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}); end
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL set_read.rd_ready got=%b exp=01", bus.rq_ready); end
      c0 = ndro_clk;
      for (int k = 0; k <= READ_LAT + 1; k++) begin
         tick(); drive(2'b10, OP_NOP, 0, OP_SET, 0); to_mid();
         if (k == 0) begin
            checks++; if (ndro_clk !== (c0 ^ 4'b0100)) begin failures++; $display("FAIL set_read.clk_pulse got=%b exp=%b", ndro_clk, c0 ^ 4'b0100); end
         end
         checks++; if (bus.rq_ready !== 2'b00) begin failures++; $display("FAIL set_read.busy_ready k=%0d got=%b exp=00", k, bus.rq_ready); end
         checks++; if (bus.rsp_valid !== (k == READ_LAT + 1)) begin failures++; $display("FAIL set_read.rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, (k == READ_LAT + 1)); end
      end
      checks++; if ({bus.rsp_id, bus.rsp_data, err} !== 3'b010) begin failures++; $display("FAIL set_read.rd_rsp id/data/err got=%b exp=010", {bus.rsp_id, bus.rsp_data, err}); end
      tick(); drive(2'b10, OP_NOP, 0, OP_SET, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b10) begin failures++; $display("FAIL set_read.after_ready got=%b exp=10", bus.rq_ready); end
      tick(); drive(2'b00, OP_NOP, 0, OP_NOP, 0);
   endtask

   task automatic test_rs_guard();
      logic [NCELL-1:0] r0, s0;
      tick(); drive(2'b01, OP_RESET, 1, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL rs_guard.reset_ready got=%b exp=01", bus.rq_ready); end
      r0 = ndro_reset; s0 = ndro_set;
      tick(); drive(2'b11, OP_SET, 1, OP_SET, 3); to_mid();
      checks++; if (bus.rq_ready !== 2'b10) begin failures++; $display("FAIL rs_guard.t1_ready got=%b exp=10", bus.rq_ready); end
      checks++; if (ndro_reset !== (r0 ^ 4'b0010)) begin failures++; $display("FAIL rs_guard.reset_pulse got=%b exp=%b", ndro_reset, r0 ^ 4'b0010); end
      tick(); drive(2'b01, OP_SET, 1, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b00) begin failures++; $display("FAIL rs_guard.t2_ready got=%b exp=00", bus.rq_ready); end
      checks++; if (ndro_set !== (s0 ^ 4'b1000)) begin failures++; $display("FAIL rs_guard.other_cell got=%b exp=%b", ndro_set, s0 ^ 4'b1000); end
      s0 = ndro_set;
      tick(); drive(2'b01, OP_SET, 1, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL rs_guard.t3_ready got=%b exp=01", bus.rq_ready); end
      tick(); drive(2'b00, OP_NOP, 0, OP_NOP, 0); to_mid();
      checks++; if (ndro_set !== (s0 ^ 4'b0010)) begin failures++; $display("FAIL rs_guard.set_pulse got=%b exp=%b", ndro_set, s0 ^ 4'b0010); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]       exp_g, prev_g;
      logic [NCELL-1:0] sp, tog;
      tick(); drive(2'b10, OP_NOP, 0, OP_SET, 3); to_mid();
      checks++; if (bus.rq_ready !== 2'b10) begin failures++; $display("FAIL b2b.sync_ready got=%b exp=10", bus.rq_ready); end
      prev_g = 2'b10; exp_g = 2'b01; sp = ndro_set;
      for (int k = 0; k < 8; k++) begin
         tick(); drive(2'b11, OP_SET, 0, OP_SET, 3); to_mid();
         tog = (prev_g == 2'b01) ? 4'b0001 : 4'b1000;
         checks++; if (bus.rq_ready !== exp_g) begin failures++; $display("FAIL b2b.grant k=%0d got=%b exp=%b", k, bus.rq_ready, exp_g); end
         checks++; if ((ndro_set ^ sp) !== tog) begin failures++; $display("FAIL b2b.pulse k=%0d got=%b exp=%b", k, ndro_set ^ sp, tog); end
         sp = ndro_set; prev_g = exp_g; exp_g = {exp_g[0], exp_g[1]};
      end
      tick(); drive(2'b00, OP_NOP, 0, OP_NOP, 0);
   endtask

   task automatic test_cr_guard();
      logic [NCELL-1:0] r0;
      tick(); drive(2'b01, OP_READ, 0, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL cr_guard.read_ready got=%b exp=01", bus.rq_ready); end
      r0 = ndro_reset;
      for (int k = 0; k <= READ_LAT + 1; k++) begin
         tick(); drive(2'b01, OP_RESET, 0, OP_NOP, 0); to_mid();
         checks++; if (bus.rq_ready !== 2'b00) begin failures++; $display("FAIL cr_guard.blocked k=%0d got=%b exp=00", k, bus.rq_ready); end
         checks++; if (bus.rsp_valid !== (k == READ_LAT + 1)) begin failures++; $display("FAIL cr_guard.rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, (k == READ_LAT + 1)); end
      end
      checks++; if (bus.rsp_data !== 1'b1) begin failures++; $display("FAIL cr_guard.rsp_data got=%b exp=1", bus.rsp_data); end
      tick(); drive(2'b01, OP_RESET, 0, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL cr_guard.accept got=%b exp=01", bus.rq_ready); end
      tick(); drive(2'b00, OP_NOP, 0, OP_NOP, 0); to_mid();
      checks++; if (ndro_reset !== (r0 ^ 4'b0001)) begin failures++; $display("FAIL cr_guard.reset_pulse got=%b exp=%b", ndro_reset, r0 ^ 4'b0001); end
   endtask

   task automatic test_random();
      logic [NCELL-1:0] m_st, e_set, e_rst, e_clk, ps, pr, pc;
      int               set_ok[NCELL], rst_ok[NCELL];
      int               idle_at, c;
      logic             rr_pref, w, exp_v;
      logic [1:0]       v, el, exp_rdy;
      logic [1:0]       o[2];
      logic [IDXW-1:0]  ix[2];
      logic [1:0]       exp_q[$];
      int               due_q[$];
      int               r8;

      do_reset();
      m_st = '0; e_set = '0; e_rst = '0; e_clk = '0; ps = '0; pr = '0; pc = '0;
      for (int i = 0; i < NCELL; i++) begin set_ok[i] = 0; rst_ok[i] = 0; end
      idle_at = 0; rr_pref = 1'b0;

      for (c = 0; c < NRAND; c++) begin
         tick();
         v = (c < NRAND - 12) ? 2'($urandom_range(0, 3)) : 2'b00;
         for (int r = 0; r < 2; r++) begin
            r8 = $urandom_range(0, 7);
            o[r]  = (r8 == 0) ? OP_NOP : (r8 < 4) ? OP_SET : (r8 < 6) ? OP_RESET : OP_READ;
            ix[r] = IDXW'($urandom_range(0, NCELL - 1));
         end
         drive(v, o[0], ix[0], o[1], ix[1]);

         for (int r = 0; r < 2; r++)
            el[r] = v[r] && (c >= idle_at)
                    && !(o[r] == OP_SET && c < set_ok[ix[r]])
                    && !(o[r] == OP_RESET && c < rst_ok[ix[r]]);
         w       = (el == 2'b11) ? rr_pref : el[1];
         exp_rdy = (el == 2'b00) ? 2'b00 : (2'b01 << w);
         exp_v   = (due_q.size() > 0) && (due_q[0] == c);

         to_mid();
         checks++; if (bus.rq_ready !== exp_rdy) begin failures++; $display("FAIL random.ready c=%0d got=%b exp=%b", c, bus.rq_ready, exp_rdy); end
         checks++; if ({ndro_set ^ ps, ndro_reset ^ pr, ndro_clk ^ pc} !== {e_set, e_rst, e_clk}) begin failures++; $display("FAIL random.pulses c=%0d got=%h exp=%h", c, {ndro_set ^ ps, ndro_reset ^ pr, ndro_clk ^ pc}, {e_set, e_rst, e_clk}); end
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL random.err c=%0d got=%b exp=0", c, err); end
         checks++; if (bus.rsp_valid !== exp_v) begin failures++; $display("FAIL random.rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, exp_v); end
         if (exp_v) begin
            checks++; if ({bus.rsp_id, bus.rsp_data} !== exp_q[0]) begin failures++; $display("FAIL random.rsp c=%0d got=%b exp=%b", c, {bus.rsp_id, bus.rsp_data}, exp_q[0]); end
            void'(exp_q.pop_front()); void'(due_q.pop_front());
         end

         ps = ndro_set; pr = ndro_reset; pc = ndro_clk;
         e_set = '0; e_rst = '0; e_clk = '0;
         if (el != 2'b00) begin
            rr_pref = ~w;
            case (o[w])
               OP_SET: begin
                  m_st[ix[w]] = 1'b1; e_set[ix[w]] = 1'b1;
                  due_q.push_back(c + 1); exp_q.push_back({w, 1'b0});
               end
               OP_RESET: begin
                  m_st[ix[w]] = 1'b0; e_rst[ix[w]] = 1'b1;
                  set_ok[ix[w]] = c + 1 + CT_RS;
                  due_q.push_back(c + 1); exp_q.push_back({w, 1'b0});
               end
               OP_READ: begin
                  e_clk[ix[w]] = 1'b1;
                  due_q.push_back(c + 2 + READ_LAT); exp_q.push_back({w, m_st[ix[w]]});
                  idle_at = c + 3 + READ_LAT;
                  if (m_st[ix[w]]) rst_ok[ix[w]] = c + 1 + CT_CR;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic test_stray();
      repeat (3) begin tick(); drive(2'b00, OP_NOP, 0, OP_NOP, 0); end
      tick(); inj[3] = 1'b1; to_mid();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL stray.same_cycle got=%b exp=0", err); end
      for (int k = 0; k < 4; k++) begin
         tick(); to_mid();
         checks++; if (err !== 1'b1) begin failures++; $display("FAIL stray.held k=%0d got=%b exp=1", k, err); end
      end
   endtask

   task automatic test_reset_mid_read();
      tick(); drive(2'b01, OP_SET, 2, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL rst_mid.set_ready got=%b exp=01", bus.rq_ready); end
      tick(); drive(2'b01, OP_READ, 2, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL rst_mid.read_ready got=%b exp=01", bus.rq_ready); end
      tick(); drive(2'b01, OP_SET, 0, OP_NOP, 0);
      tick(); #1;
      reset = 1'b0; inj = '0;
      #1;
      checks++; if ({bus.rq_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, err} !== '0) begin failures++; $display("FAIL rst_mid.async_ctl got=%b exp=0", {bus.rq_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, err}); end
      checks++; if ({ndro_set, ndro_reset, ndro_clk} !== '0) begin failures++; $display("FAIL rst_mid.async_ndro got=%h exp=0", {ndro_set, ndro_reset, ndro_clk}); end
      checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_mid.state got=%0d exp=0", dbg_state); end
      drive(2'b00, OP_NOP, 0, OP_NOP, 0);
      tick(); tick();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(); to_mid();
         checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid.dropped k=%0d got=%b exp=0", k, bus.rsp_valid); end
      end
      tick(); drive(2'b01, OP_READ, 2, OP_NOP, 0); to_mid();
      checks++; if (bus.rq_ready !== 2'b01) begin failures++; $display("FAIL rst_mid.reread_ready got=%b exp=01", bus.rq_ready); end
      for (int k = 0; k <= READ_LAT + 1; k++) begin
         tick(); drive(2'b00, OP_NOP, 0, OP_NOP, 0); to_mid();
         checks++; if (bus.rsp_valid !== (k == READ_LAT + 1)) begin failures++; $display("FAIL rst_mid.rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, (k == READ_LAT + 1)); end
      end
      checks++; if ({bus.rsp_data, err} !== 2'b00) begin failures++; $display("FAIL rst_mid.reread data/err got=%b exp=00", {bus.rsp_data, err}); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b0;
      inj   = '0;
      drive(2'b00, OP_NOP, 0, OP_NOP, 0);
      test_reset();
      test_set_read();
      test_rs_guard();
      test_back_to_back();
      test_cr_guard();
      test_random();
      test_stray();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
